// File: rtl/risc_id_ex_fwd.sv
// ID/EX pipeline register with EX-stage operand forwarding
// and single-cycle load-use stall generation.
module risc_id_ex_fwd #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0] id_rd_dataA,
  input  logic [DATA_WIDTH-1:0] id_rd_dataB,
  input  logic [DATA_WIDTH-1:0] id_imm_ext,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_operandA,
  output logic [DATA_WIDTH-1:0] ex_operandB,
  output logic [DATA_WIDTH-1:0] ex_store_data,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read
);

  logic                  v_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  alu_src_q;
  logic                  rw_q;
  logic                  mr_q;

  logic                  hit_rs1;
  logic                  hit_rs2;
  logic                  rd_nz;
  logic                  bubble;
  logic [DATA_WIDTH-1:0] cap_a;
  logic [DATA_WIDTH-1:0] cap_b;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR_W-1:0] src,
    input logic [DATA_WIDTH-1:0] held,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic [DATA_WIDTH-1:0] m_val,
    input logic                  w_we,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic [DATA_WIDTH-1:0] w_val
  );
    logic [DATA_WIDTH-1:0] r;
    // Youngest producer wins: EX/MEM before MEM/WB.
    if (src == '0)
      r = '0;
    else if (m_we && m_rd == src)
      r = m_val;
    else if (w_we && w_rd == src)
      r = w_val;
    else
      r = held;
    return r;
  endfunction

  // Any rs2 match counts, even when rs2 is not read.
  always_comb begin
    hit_rs1 = (rd_q == id_rs1);
    hit_rs2 = (rd_q == id_rs2);
    rd_nz   = (rd_q != '0);
    stall   = !flush && id_valid && v_q && mr_q
              && rd_nz && (hit_rs1 || hit_rs2);
    bubble  = flush || stall;
  end

  always_comb begin
    cap_a = id_rd_dataA;
    cap_b = id_rd_dataB;
    if (wb_reg_write && wb_rd != '0 && wb_rd == id_rs1)
      cap_a = wb_data;
    if (wb_reg_write && wb_rd != '0 && wb_rd == id_rs2)
      cap_b = wb_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v_q       <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      alu_src_q <= 1'b0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
    end else if (bubble) begin
      v_q  <= 1'b0;
      rw_q <= 1'b0;
      mr_q <= 1'b0;
    end else begin
      v_q       <= id_valid;
      rs1_q     <= id_rs1;
      rs2_q     <= id_rs2;
      rd_q      <= id_rd;
      a_q       <= cap_a;
      b_q       <= cap_b;
      imm_q     <= id_imm_ext;
      pc_q      <= id_pc;
      alu_src_q <= id_alu_src;
      rw_q      <= id_reg_write;
      mr_q      <= id_mem_read;
    end
  end

  always_comb begin
    fwd_a = fwd(rs1_q, a_q,
                mem_reg_write, mem_rd, mem_result,
                wb_reg_write, wb_rd, wb_data);
    fwd_b = fwd(rs2_q, b_q,
                mem_reg_write, mem_rd, mem_result,
                wb_reg_write, wb_rd, wb_data);
  end

  assign ex_valid      = v_q;
  assign ex_operandA   = fwd_a;
  assign ex_operandB   = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_imm        = imm_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = rw_q && v_q;
  assign ex_mem_read   = mr_q && v_q;

endmodule

// File: tb/tb_risc_id_ex_fwd.sv
// Bench for risc_id_ex_fwd: directed vector table, random
// stimulus against a reference model, reset corner cases.
module tb_risc_id_ex_fwd;

  logic        clk;
  logic        nrst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rd_dataA;
  logic [31:0] id_rd_dataB;
  logic [31:0] id_imm_ext;
  logic [31:0] id_pc;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_operandA;
  logic [31:0] ex_operandB;
  logic [31:0] ex_store_data;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;

  risc_id_ex_fwd #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .nrst(nrst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rd_dataA(id_rd_dataA),
    .id_rd_dataB(id_rd_dataB), .id_imm_ext(id_imm_ext),
    .id_pc(id_pc), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid),
    .ex_operandA(ex_operandA), .ex_operandB(ex_operandB),
    .ex_store_data(ex_store_data), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic [31:0] da; logic [31:0] db;
    logic [31:0] imm; logic [31:0] pc;
    logic alu; logic rw; logic mr;
  } id_t;

  typedef struct {
    logic fl; logic [4:0] mrd; logic mrw; logic [31:0] mres;
    logic [4:0] wrd; logic wrw; logic [31:0] wdat;
  } env_t;

  typedef struct {
    logic st; logic v; logic chk;
    logic [31:0] a; logic [31:0] b; logic [31:0] sd;
  } exp_t;

  typedef struct { id_t id; env_t env; exp_t ex; } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  function automatic id_t idf(logic v, logic [4:0] rs1,
      logic [4:0] rs2, logic [4:0] rd, logic [31:0] da,
      logic [31:0] db, logic [31:0] imm, logic [31:0] pc,
      logic alu, logic rw, logic mr);
    id_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.da = da; r.db = db; r.imm = imm; r.pc = pc;
    r.alu = alu; r.rw = rw; r.mr = mr;
    return r;
  endfunction

  function automatic env_t envf(logic fl, logic [4:0] mrd,
      logic mrw, logic [31:0] mres, logic [4:0] wrd,
      logic wrw, logic [31:0] wdat);
    env_t r;
    r.fl = fl; r.mrd = mrd; r.mrw = mrw; r.mres = mres;
    r.wrd = wrd; r.wrw = wrw; r.wdat = wdat;
    return r;
  endfunction

  function automatic exp_t expf(logic st, logic v, logic chk,
      logic [31:0] a, logic [31:0] b, logic [31:0] sd);
    exp_t r;
    r.st = st; r.v = v; r.chk = chk;
    r.a = a; r.b = b; r.sd = sd;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive_id(id_t d);
    id_valid = d.v; id_rs1 = d.rs1; id_rs2 = d.rs2;
    id_rd = d.rd; id_rd_dataA = d.da; id_rd_dataB = d.db;
    id_imm_ext = d.imm; id_pc = d.pc; id_alu_src = d.alu;
    id_reg_write = d.rw; id_mem_read = d.mr;
  endtask

  task automatic drive_env(env_t e);
    flush = e.fl; mem_rd = e.mrd; mem_reg_write = e.mrw;
    mem_result = e.mres; wb_rd = e.wrd;
    wb_reg_write = e.wrw; wb_data = e.wdat;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, " stall"}, 32'(stall), 0);
    check({tag, " ex_valid"}, 32'(ex_valid), 0);
    check({tag, " opA"}, ex_operandA, 0);
    check({tag, " opB"}, ex_operandB, 0);
    check({tag, " sd"}, ex_store_data, 0);
    check({tag, " imm"}, ex_imm, 0);
    check({tag, " pc"}, ex_pc, 0);
    check({tag, " rd"}, 32'(ex_rd), 0);
    check({tag, " rw"}, 32'(ex_reg_write), 0);
    check({tag, " mr"}, 32'(ex_mem_read), 0);
  endtask

  task automatic random_inputs();
    id_valid = 1'($urandom); id_rs1 = 5'($urandom_range(0, 7));
    id_rs2 = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7));
    id_rd_dataA = $urandom; id_rd_dataB = $urandom;
    id_imm_ext = $urandom; id_pc = $urandom;
    id_alu_src = 1'($urandom);
    id_reg_write = 1'($urandom);
    id_mem_read = ($urandom_range(0, 3) == 0);
    flush = ($urandom_range(0, 9) == 0);
    mem_rd = 5'($urandom_range(0, 7));
    mem_reg_write = 1'($urandom); mem_result = $urandom;
    wb_rd = 5'($urandom_range(0, 7));
    wb_reg_write = 1'($urandom); wb_data = $urandom;
  endtask

  // Reference model: the instruction currently occupying EX.
  id_t m;

  function automatic logic [31:0] ref_val(logic [4:0] src,
                                          logic [31:0] held);
    logic [4:0]  prd [2];
    logic        pwe [2];
    logic [31:0] pval [2];
    prd[0] = mem_rd; pwe[0] = mem_reg_write; pval[0] = mem_result;
    prd[1] = wb_rd;  pwe[1] = wb_reg_write;  pval[1] = wb_data;
    if (src == 0) return 0;
    for (int i = 0; i < 2; i++)
      if (pwe[i] && prd[i] == src) return pval[i];
    return held;
  endfunction

  function automatic logic ref_stall();
    logic dep;
    dep = (m.rd == id_rs1) || (m.rd == id_rs2);
    return !flush && id_valid && m.v && m.mr && m.rd != 0 && dep;
  endfunction

  function automatic logic [31:0] rf_read(logic [4:0] src,
                                          logic [31:0] port);
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return wb_data;
    return port;
  endfunction

  vec_t tbl [13];

  initial begin
    id_t nop;
    env_t q;
    logic exp_st;
    nop = idf(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    q = envf(0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{idf(1, 3, 0, 1, 'h11, 0, 0, 'h100, 0, 1, 0), q,
                expf(0, 0, 1, 0, 0, 0)};
    tbl[1]  = '{idf(1, 5, 6, 2, 1, 2, 0, 'h104, 0, 1, 0), q,
                expf(0, 1, 1, 'h11, 0, 0)};
    tbl[2]  = '{idf(1, 5, 6, 2, 1, 2, 0, 'h108, 0, 1, 0),
                envf(0, 5, 1, 'hAAAA, 5, 1, 'hBBBB),
                expf(0, 1, 1, 'hAAAA, 2, 2)};
    tbl[3]  = '{idf(1, 0, 0, 3, 'h77, 0, 0, 'h10C, 0, 1, 0),
                envf(0, 5, 0, 'hAAAA, 5, 1, 'hBBBB),
                expf(0, 1, 1, 'hBBBB, 2, 2)};
    tbl[4]  = '{idf(1, 1, 0, 7, 'h1000, 0, 4, 'h110, 1, 1, 1),
                envf(0, 0, 1, 'h1234, 0, 0, 0),
                expf(0, 1, 1, 0, 0, 0)};
    tbl[5]  = '{idf(1, 2, 7, 8, 'h20, 0, 0, 'h114, 0, 1, 0), q,
                expf(1, 1, 1, 'h1000, 4, 0)};
    tbl[6]  = '{idf(1, 2, 7, 8, 'h20, 0, 0, 'h114, 0, 1, 0), q,
                expf(0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{nop, envf(0, 0, 0, 0, 7, 1, 'hCAFE),
                expf(0, 1, 1, 'h20, 'hCAFE, 'hCAFE)};
    tbl[8]  = '{idf(1, 0, 9, 4, 0, 0, 0, 'h118, 0, 0, 0),
                envf(0, 0, 0, 0, 9, 1, 'h55),
                expf(0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{idf(1, 0, 0, 10, 0, 0, 8, 'h11C, 1, 1, 1), q,
                expf(0, 1, 1, 0, 'h55, 'h55)};
    tbl[10] = '{idf(1, 10, 0, 11, 0, 0, 0, 'h120, 0, 1, 0),
                envf(1, 0, 0, 0, 0, 0, 0),
                expf(0, 1, 1, 0, 8, 0)};
    tbl[11] = '{idf(1, 0, 12, 5, 0, 0, 'hFFFFFFF0, 'h124, 1, 1, 0),
                q, expf(0, 0, 0, 0, 0, 0)};
    tbl[12] = '{nop, envf(0, 12, 1, 'h999, 12, 1, 'h888),
                expf(0, 1, 1, 0, 'hFFFFFFF0, 'h999)};

    // Reset with random inputs.
    nrst = 1'b0;
    random_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      random_inputs();
      #2;
      check_all_zero("reset");
    end
    @(negedge clk);
    nrst = 1'b1;
    drive_id(nop);
    drive_env(q);

    // Directed vector table.
    foreach (tbl[i]) begin
      @(negedge clk);
      drive_id(tbl[i].id);
      drive_env(tbl[i].env);
      #2;
      check($sformatf("vec%0d stall", i), 32'(stall),
            32'(tbl[i].ex.st));
      check($sformatf("vec%0d ex_valid", i), 32'(ex_valid),
            32'(tbl[i].ex.v));
      if (tbl[i].ex.chk) begin
        check($sformatf("vec%0d opA", i), ex_operandA, tbl[i].ex.a);
        check($sformatf("vec%0d opB", i), ex_operandB, tbl[i].ex.b);
        check($sformatf("vec%0d sd", i), ex_store_data,
              tbl[i].ex.sd);
      end
    end

    // Random stimulus against the model.
    @(negedge clk);
    nrst = 1'b0;
    m = nop;
    #2;
    nrst = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      random_inputs();
      #2;
      exp_st = ref_stall();
      check("rnd stall", 32'(stall), 32'(exp_st));
      check("rnd ex_valid", 32'(ex_valid), 32'(m.v));
      check("rnd opA", ex_operandA, ref_val(m.rs1, m.da));
      check("rnd opB", ex_operandB,
            m.alu ? m.imm : ref_val(m.rs2, m.db));
      check("rnd sd", ex_store_data, ref_val(m.rs2, m.db));
      check("rnd imm", ex_imm, m.imm);
      check("rnd pc", ex_pc, m.pc);
      check("rnd rd", 32'(ex_rd), 32'(m.rd));
      check("rnd rw", 32'(ex_reg_write), 32'(m.rw && m.v));
      check("rnd mr", 32'(ex_mem_read), 32'(m.mr && m.v));
      @(posedge clk);
      if (flush || exp_st) begin
        m.v = 0; m.rw = 0; m.mr = 0;
      end else begin
        m = idf(id_valid, id_rs1, id_rs2, id_rd,
                rf_read(id_rs1, id_rd_dataA),
                rf_read(id_rs2, id_rd_dataB),
                id_imm_ext, id_pc, id_alu_src,
                id_reg_write, id_mem_read);
      end
    end

    // Reset asserted while a load-use stall is active.
    @(negedge clk);
    drive_env(q);
    drive_id(idf(1, 0, 0, 6, 0, 0, 0, 'h200, 1, 1, 1));
    @(negedge clk);
    drive_id(idf(1, 6, 0, 9, 0, 0, 0, 'h204, 0, 1, 0));
    #2;
    check("midstall stall before", 32'(stall), 1);
    #1;
    nrst = 1'b0;
    #1;
    check("midstall stall after", 32'(stall), 0);
    check("midstall ex_valid", 32'(ex_valid), 0);
    check("midstall mr", 32'(ex_mem_read), 0);
    @(negedge clk);
    nrst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
